// File: rtl/mux_arb_pipe.sv
// Registered N:1 word selector with valid/ready on every channel.
// Direct-select or round-robin arbitration feeds a single back-pressured output register.
module mux_arb_pipe #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             take;
    logic             xfer;

    // Descending scan so the channel closest to rr_ptr is written last and wins.
    always_comb begin
        rr_grant = rr_ptr_q;
        rr_found = 1'b0;
        idx      = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            idx = rr_ptr_q + SEL_W'(i);
            if (in_valid[idx]) begin
                rr_grant = idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        grant    = mode ? rr_grant : sel;
        grant_ok = mode ? rr_found : 1'b1;
        take     = !valid_q || out_ready;
        in_ready = '0;
        if (!reset && take && grant_ok) begin
            in_ready = NUM_IN'(1) << grant;
        end
        xfer = |(in_valid & in_ready);
    end

    always_comb begin
        data_d   = data_q;
        ch_d     = ch_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            data_d  = in_data[grant*WIDTH +: WIDTH];
            ch_d    = grant;
            valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = grant + SEL_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            data_q   <= data_d;
            ch_q     <= ch_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Directed bench for mux_arb_pipe: a 64-bit/4-channel instance driven from a vector
// table plus hand sequences for reset, and an 8-bit/8-channel instance.
module tb_mux_arb_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;

    logic         a_mode;
    logic [1:0]   a_sel;
    logic [255:0] a_in_data;
    logic [3:0]   a_in_valid;
    logic [3:0]   a_in_ready;
    logic [63:0]  a_out_data;
    logic [1:0]   a_out_ch;
    logic         a_out_valid;
    logic         a_out_ready;

    logic         b_mode;
    logic [2:0]   b_sel;
    logic [63:0]  b_in_data;
    logic [7:0]   b_in_valid;
    logic [7:0]   b_in_ready;
    logic [7:0]   b_out_data;
    logic [2:0]   b_out_ch;
    logic         b_out_valid;
    logic         b_out_ready;

    mux_arb_pipe #(.WIDTH(64), .NUM_IN(4), .SEL_W(2)) dut_a (
        .clk(clk), .reset(reset), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_ch(a_out_ch), .out_valid(a_out_valid),
        .out_ready(a_out_ready)
    );

    mux_arb_pipe #(.WIDTH(8), .NUM_IN(8), .SEL_W(3)) dut_b (
        .clk(clk), .reset(reset), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_ch(b_out_ch), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    typedef struct {
        logic         mode;
        logic [1:0]   sel;
        logic [3:0]   iv;
        logic [255:0] din;
        logic         ordy;
        logic [3:0]   e_ir;
        logic         e_ov;
        logic [63:0]  e_od;
        logic [1:0]   e_ch;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] w0, input logic [63:0] w1,
                                           input logic [63:0] w2, input logic [63:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                                input logic [255:0] din, input logic r, input logic [3:0] eir,
                                input logic eov, input logic [63:0] eod, input logic [1:0] ech);
        vec_t v;
        v.mode = m; v.sel = s; v.iv = iv; v.din = din; v.ordy = r;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_ch = ech;
        return v;
    endfunction

    task automatic drive_a(input logic m, input logic [1:0] s, input logic [3:0] iv,
                           input logic [255:0] din, input logic r);
        a_mode = m; a_sel = s; a_in_valid = iv; a_in_data = din; a_out_ready = r;
    endtask

    function automatic logic [7:0] b_word(input int k);
        return (k == 7) ? 8'hA5 : 8'(8'h10 + k);
    endfunction

    vec_t vt[25];
    logic [255:0] DA, DB, DC, DD;

    initial begin
        DA = pack4(64'hA0A0, 64'hA1A1, 64'h0123456789ABCDEF, 64'hA3A3);
        DB = pack4(64'hB0B0, 64'hB1B1, 64'hB2B2, 64'hB3B3);
        DC = pack4(64'hC0C0, 64'hC1C1, 64'hC2C2, 64'hC3C3);
        DD = pack4(64'h1111, 64'hDEAD, 64'h2222, 64'h3333);

        // mode 0 basic, then back-pressure with changing sel/data
        vt[0]  = mk(0, 2, 4'b0100, DA, 1, 4'b0100, 1, 64'h0123456789ABCDEF, 2);
        vt[1]  = mk(0, 3, 4'b0100, DA, 1, 4'b1000, 0, 64'h0123456789ABCDEF, 2);
        vt[2]  = mk(0, 1, 4'b0010, DA, 0, 4'b0010, 1, 64'hA1A1, 1);
        vt[3]  = mk(0, 0, 4'b0001, DB, 0, 4'b0000, 1, 64'hA1A1, 1);
        vt[4]  = mk(0, 2, 4'b0100, DB, 0, 4'b0000, 1, 64'hA1A1, 1);
        vt[5]  = mk(0, 3, 4'b1000, DB, 0, 4'b0000, 1, 64'hA1A1, 1);
        vt[6]  = mk(0, 3, 4'b1000, DB, 1, 4'b1000, 1, 64'hB3B3, 3);
        vt[7]  = mk(0, 0, 4'b0000, DB, 1, 4'b0001, 0, 64'hB3B3, 3);
        // round-robin, all valid
        vt[8]  = mk(1, 0, 4'b1111, DC, 1, 4'b0001, 1, 64'hC0C0, 0);
        vt[9]  = mk(1, 0, 4'b1111, DC, 1, 4'b0010, 1, 64'hC1C1, 1);
        vt[10] = mk(1, 0, 4'b1111, DC, 1, 4'b0100, 1, 64'hC2C2, 2);
        vt[11] = mk(1, 0, 4'b1111, DC, 1, 4'b1000, 1, 64'hC3C3, 3);
        vt[12] = mk(1, 0, 4'b1111, DC, 1, 4'b0001, 1, 64'hC0C0, 0);
        vt[13] = mk(1, 0, 4'b1111, DC, 1, 4'b0010, 1, 64'hC1C1, 1);
        // sparse valid from rr_ptr=2: 3,1,3
        vt[14] = mk(1, 0, 4'b1010, DC, 1, 4'b1000, 1, 64'hC3C3, 3);
        vt[15] = mk(1, 0, 4'b1010, DC, 1, 4'b0010, 1, 64'hC1C1, 1);
        vt[16] = mk(1, 0, 4'b1010, DC, 1, 4'b1000, 1, 64'hC3C3, 3);
        // move rr_ptr to 3, then wrap to channel 0
        vt[17] = mk(1, 0, 4'b0100, DC, 1, 4'b0100, 1, 64'hC2C2, 2);
        vt[18] = mk(1, 0, 4'b0001, DC, 1, 4'b0001, 1, 64'hC0C0, 0);
        vt[19] = mk(1, 0, 4'b0000, DC, 1, 4'b0000, 0, 64'hC0C0, 0);
        vt[20] = mk(1, 0, 4'b1111, DC, 1, 4'b0010, 1, 64'hC1C1, 1);
        // mode-0 transfer must leave rr_ptr at 2
        vt[21] = mk(0, 0, 4'b0001, DC, 1, 4'b0001, 1, 64'hC0C0, 0);
        vt[22] = mk(1, 0, 4'b1111, DC, 1, 4'b0100, 1, 64'hC2C2, 2);
        vt[23] = mk(1, 0, 4'b1111, DC, 0, 4'b0000, 1, 64'hC2C2, 2);
        vt[24] = mk(1, 0, 4'b1111, DC, 1, 4'b1000, 1, 64'hC3C3, 3);

        reset = 1'b1;
        drive_a(0, 0, 4'b0000, '0, 1);
        b_mode = 0; b_sel = 0; b_in_valid = '0; b_in_data = '0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("a_reset_valid", 64'(a_out_valid), 64'd0);
        chk("a_reset_data",  a_out_data, 64'd0);
        chk("a_reset_ch",    64'(a_out_ch), 64'd0);
        chk("b_reset_valid", 64'(b_out_valid), 64'd0);
        chk("b_reset_data",  64'(b_out_data), 64'd0);
        chk("b_reset_ch",    64'(b_out_ch), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive_a(vt[i].mode, vt[i].sel, vt[i].iv, vt[i].din, vt[i].ordy);
            #1;
            chk($sformatf("v%0d_in_ready", i), 64'(a_in_ready), 64'(vt[i].e_ir));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 64'(a_out_valid), 64'(vt[i].e_ov));
            chk($sformatf("v%0d_out_data", i), a_out_data, vt[i].e_od);
            chk($sformatf("v%0d_out_ch", i), 64'(a_out_ch), 64'(vt[i].e_ch));
        end

        // reset mid-operation: load 0xDEAD via rr (rr_ptr -> 2), hold it, then reset
        drive_a(1, 0, 4'b0010, DD, 1);
        @(posedge clk); #1;
        chk("rst_load_data", a_out_data, 64'hDEAD);
        chk("rst_load_ch",   64'(a_out_ch), 64'd1);
        drive_a(1, 0, 4'b0010, DD, 0);
        @(posedge clk); #1;
        chk("rst_hold_valid", 64'(a_out_valid), 64'd1);
        reset = 1'b1;
        drive_a(1, 0, 4'b1111, DD, 1);
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data",  a_out_data, 64'd0);
        chk("rst_out_ch",    64'(a_out_ch), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'b0001);
        @(posedge clk); #1;
        chk("post_rst_data", a_out_data, 64'h1111);
        chk("post_rst_ch",   64'(a_out_ch), 64'd0);
        chk("post_rst_valid", 64'(a_out_valid), 64'd1);

        // 8-bit / 8-channel instance
        for (int k = 0; k < 8; k++) b_in_data[k*8 +: 8] = b_word(k);
        b_mode = 0; b_sel = 3'd7; b_in_valid = 8'h80; b_out_ready = 1;
        #1;
        chk("b_m0_in_ready", 64'(b_in_ready), 64'h80);
        @(posedge clk); #1;
        chk("b_m0_data", 64'(b_out_data), 64'hA5);
        chk("b_m0_ch",   64'(b_out_ch), 64'd7);
        b_mode = 1; b_in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("b_rr%0d_in_ready", i), 64'(b_in_ready), 64'(8'd1 << (i % 8)));
            @(posedge clk); #1;
            chk($sformatf("b_rr%0d_data", i), 64'(b_out_data), 64'(b_word(i % 8)));
            chk($sformatf("b_rr%0d_ch", i),   64'(b_out_ch), 64'(i % 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
